// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point min/max reduction slice.
//   - default operand geometry (fp16) and the widest operand the helper
//     functions can handle (FP_MAX_W bits)
//   - reduction FSM state encoding
//   - helper functions: NaN detection, total-order key, canonical qNaN
// Helpers work on a zero-extended FP_MAX_W-bit word and take the field widths
// as arguments, so any EXP_W/MAN_W combination up to 64 bits total can use them.
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_MAX_W       = 64;
    localparam int FP_DEF_EXP_W   = 5;
    localparam int FP_DEF_MAN_W   = 10;
    localparam int FP_DEF_W       = 1 + FP_DEF_EXP_W + FP_DEF_MAN_W;
    localparam int FP_DEF_IDX_W   = 8;

    typedef logic [FP_MAX_W-1:0] fp_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // All-ones mask of the given width (a width of FP_MAX_W wraps to all ones).
    function automatic fp_word_t fp_field_mask(input int width);
        return (fp_word_t'(1) << width) - fp_word_t'(1);
    endfunction

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic fp_is_nan(input fp_word_t x, input int exp_w, input int man_w);
        fp_word_t exp_mask;
        logic     exp_ones;
        logic     man_nz;
        exp_mask = fp_field_mask(exp_w);
        exp_ones = ((x >> man_w) & exp_mask) == exp_mask;
        man_nz   = (x & fp_field_mask(man_w)) != '0;
        return exp_ones && man_nz;
    endfunction

    // Maps a w-bit operand onto an unsigned key whose ordering matches the
    // numeric ordering, with -0 sorting just below +0.
    function automatic fp_word_t fp_order_key(input fp_word_t x, input int w);
        fp_word_t w_mask;
        fp_word_t sign_bit;
        w_mask   = fp_field_mask(w);
        sign_bit = fp_word_t'(1) << (w - 1);
        if ((x & sign_bit) != '0) begin
            return ~x & w_mask;
        end
        return (x | sign_bit) & w_mask;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic fp_word_t fp_qnan(input int exp_w, input int man_w);
        return (fp_field_mask(exp_w) << man_w) | (fp_word_t'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// ---------------------------------------------------------------------------
// fp_order_cmp
// Combinational "is b strictly better than a" test under the total order of
// non-NaN floating-point values. NaN operands are the caller's problem.
// Ports:
//   a        in  W  current champion
//   b        in  W  challenger
//   mode     in  1  0 = better means greater, 1 = better means smaller
//   b_better out 1  b strictly beats a (ties report 0)
// ---------------------------------------------------------------------------
module fp_order_cmp
    import fp_pkg::*;
#(
    parameter int W = FP_DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic         b_better
);

    logic [W-1:0] key_a;
    logic [W-1:0] key_b;

    // Keys compare as plain unsigned numbers; strict compare keeps ties on a.
    always_comb begin
        key_a    = W'(fp_order_key(fp_word_t'(a), W));
        key_b    = W'(fp_order_key(fp_word_t'(b), W));
        b_better = mode ? (key_b < key_a) : (key_b > key_a);
    end

endmodule

// File: rtl/fp_minmax_reduce.sv
// ---------------------------------------------------------------------------
// fp_minmax_reduce
// Streaming min/max reduction over framed floating-point operands. Keeps a
// running extremum and its index, and presents the result one cycle after
// the last beat of a frame is accepted.
// Ports:
//   iClk, iRst_n        clock, asynchronous active-low reset
//   iMode               0 = max, 1 = min (taken from the first beat only)
//   iValid/oReady       input beat handshake
//   iData, iLast        operand, end-of-frame marker
//   oValid/iReady       result handshake
//   oZ                  reduced value (canonical qNaN if the frame held a NaN)
//   oIdx                index of the selected (or first NaN) element
//   oNaN                frame contained a NaN
//   oOvf                frame was longer than 2^IDX_W beats
// Operand width W = 1+EXP_W+MAN_W must not exceed 64.
// ---------------------------------------------------------------------------
module fp_minmax_reduce
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_DEF_EXP_W,
    parameter int MAN_W = FP_DEF_MAN_W,
    parameter int IDX_W = FP_DEF_IDX_W
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iMode,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [1+EXP_W+MAN_W-1:0]   iData,
    input  logic                       iLast,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [1+EXP_W+MAN_W-1:0]   oZ,
    output logic [IDX_W-1:0]           oIdx,
    output logic                       oNaN,
    output logic                       oOvf
);

    localparam int               W       = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0]     QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [IDX_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             mode_q, mode_d;
    logic             nan_q, nan_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             consume;
    logic             first_beat;
    logic             in_nan;
    logic             in_better;

    // A pending result only blocks input while downstream is stalling it, so
    // a new frame can start in the same cycle the previous result drains.
    assign oReady = (state_q != DONE) || iReady;

    // Handshake decode. Any beat accepted outside ACCUM opens a new frame.
    always_comb begin
        accept     = iValid && oReady;
        consume    = (state_q == DONE) && iReady;
        first_beat = accept && (state_q != ACCUM);
        in_nan     = fp_is_nan(fp_word_t'(iData), EXP_W, MAN_W);
    end

    fp_order_cmp #(
        .W (W)
    ) u_cmp (
        .a        (acc_q),
        .b        (iData),
        .mode     (mode_q),
        .b_better (in_better)
    );

    // Next-state and accumulator update.
    // cnt_q is the index the next beat will get. It stops at CNT_MAX; sat_q
    // records that the beat at CNT_MAX has been taken, so only beats beyond
    // 2^IDX_W are flagged as overflow and kept out of the comparison.
    // Once a NaN is captured the accumulator is frozen for the rest of the frame.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        mode_d  = mode_q;
        nan_d   = nan_q;
        ovf_d   = ovf_q;

        if (consume && !accept) begin
            state_d = IDLE;
        end

        if (first_beat) begin
            mode_d  = iMode;
            acc_d   = in_nan ? QNAN : iData;
            idx_d   = '0;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
            nan_d   = in_nan;
            ovf_d   = 1'b0;
            state_d = iLast ? DONE : ACCUM;
        end else if (accept) begin
            if (in_nan && !nan_q) begin
                nan_d = 1'b1;
                acc_d = QNAN;
                idx_d = cnt_q;
            end else if (!nan_q && !in_nan && !sat_q && in_better) begin
                acc_d = iData;
                idx_d = cnt_q;
            end

            if (sat_q) begin
                ovf_d = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end

            if (iLast) begin
                state_d = DONE;
            end
        end
    end

    // State and datapath registers; reset drops any partial frame or result.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            mode_q  <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            mode_q  <= mode_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from registers, so they hold while DONE stalls.
    always_comb begin
        oValid = (state_q == DONE);
        oZ     = acc_q;
        oIdx   = idx_q;
        oNaN   = nan_q;
        oOvf   = ovf_q;
    end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// ---------------------------------------------------------------------------
// tb_fp_minmax_reduce
// Directed bench for fp_minmax_reduce in fp16 with a 2-bit index, so frames
// longer than four beats overflow. A table of frames with hand-computed
// results is run first, then backpressure and mid-frame reset sequences.
// ---------------------------------------------------------------------------
module tb_fp_minmax_reduce;

    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_mode;
    logic             i_valid;
    logic             o_ready;
    logic [15:0]      i_data;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [15:0]      o_z;
    logic [IDX_W-1:0] o_idx;
    logic             o_nan;
    logic             o_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            name;
        logic             mode;
        int               n;
        logic [5:0][15:0] d;
        logic [15:0]      z;
        int               idx;
        logic             nan;
        logic             ovf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fp_minmax_reduce #(
        .EXP_W (5),
        .MAN_W (10),
        .IDX_W (IDX_W)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iMode  (i_mode),
        .iValid (i_valid),
        .oReady (o_ready),
        .iData  (i_data),
        .iLast  (i_last),
        .oValid (o_valid),
        .iReady (i_ready),
        .oZ     (o_z),
        .oIdx   (o_idx),
        .oNaN   (o_nan),
        .oOvf   (o_ovf)
    );

    // One comparison; the only place failures are counted.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic mode, input int n,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input logic [15:0] d4, input logic [15:0] d5,
                          input logic [15:0] z, input int idx,
                          input logic nan, input logic ovf);
        vec_t v;
        v.name = name;
        v.mode = mode;
        v.n    = n;
        v.d    = {d5, d4, d3, d2, d1, d0};
        v.z    = z;
        v.idx  = idx;
        v.nan  = nan;
        v.ovf  = ovf;
        vecs.push_back(v);
    endtask

    // Offers one beat and returns #1 after the edge that accepted it.
    task automatic sendBeat(input logic [15:0] d, input logic last, input logic mode);
        int n;
        n       = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        i_mode  = mode;
        #1;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checkOutput("accept_timeout", 32'(o_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Sends a whole frame; beats after the first carry the opposite mode,
    // which the unit must ignore.
    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            sendBeat(v.d[i], (i == v.n - 1), (i == 0) ? v.mode : ~v.mode);
        end
    endtask

    task automatic drainResult(input string name);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        checkOutput({name, "_drained"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        i_mode  = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;

        // name, mode, beats, data x6, z, idx, nan, ovf
        addVec("max_basic", 1'b0, 4, 16'h3C00, 16'hC000, 16'h4000, 16'h3C00, 16'h0, 16'h0, 16'h4000, 2, 1'b0, 1'b0);
        addVec("min_zero",  1'b1, 3, 16'h0000, 16'h8000, 16'h0000, 16'h0,    16'h0, 16'h0, 16'h8000, 1, 1'b0, 1'b0);
        addVec("max_tie",   1'b0, 2, 16'h4000, 16'h4000, 16'h0,    16'h0,    16'h0, 16'h0, 16'h4000, 0, 1'b0, 1'b0);
        addVec("max_nan",   1'b0, 3, 16'h7C00, 16'h7E01, 16'h7C00, 16'h0,    16'h0, 16'h0, 16'h7E00, 1, 1'b1, 1'b0);
        addVec("max_ovf",   1'b0, 5, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h0, 16'h4400, 3, 1'b0, 1'b1);
        addVec("single",    1'b0, 1, 16'hFC00, 16'h0,    16'h0,    16'h0,    16'h0, 16'h0, 16'hFC00, 0, 1'b0, 1'b0);
        addVec("min_ninf",  1'b1, 4, 16'h3C00, 16'hFC00, 16'h7C00, 16'hC000, 16'h0, 16'h0, 16'hFC00, 1, 1'b0, 1'b0);
        addVec("min_nan0",  1'b1, 2, 16'h7C01, 16'h0000, 16'h0,    16'h0,    16'h0, 16'h0, 16'h7E00, 0, 1'b1, 1'b0);
        addVec("max_denorm",1'b0, 3, 16'h0001, 16'h8001, 16'h0000, 16'h0,    16'h0, 16'h0, 16'h0001, 0, 1'b0, 1'b0);
        addVec("max_negden",1'b0, 2, 16'h8001, 16'h8002, 16'h0,    16'h0,    16'h0, 16'h0, 16'h8001, 0, 1'b0, 1'b0);
        addVec("min_neg",   1'b1, 3, 16'hC000, 16'hC400, 16'hC200, 16'h0,    16'h0, 16'h0, 16'hC400, 1, 1'b0, 1'b0);

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_z",     32'(o_z),     32'd0);
        checkOutput("rst_idx",   32'(o_idx),   32'd0);
        checkOutput("rst_nan",   32'(o_nan),   32'd0);
        checkOutput("rst_ovf",   32'(o_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(o_ready), 32'd1);

        // Table-driven frames.
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput({vecs[k].name, "_valid"}, 32'(o_valid), 32'd1);
            checkOutput({vecs[k].name, "_z"},     32'(o_z),     32'(vecs[k].z));
            checkOutput({vecs[k].name, "_idx"},   32'(o_idx),   32'(vecs[k].idx));
            checkOutput({vecs[k].name, "_nan"},   32'(o_nan),   32'(vecs[k].nan));
            checkOutput({vecs[k].name, "_ovf"},   32'(o_ovf),   32'(vecs[k].ovf));
            drainResult(vecs[k].name);
        end

        // Backpressure: result stalls for five cycles while the next frame waits.
        sendBeat(16'h4000, 1'b0, 1'b0);
        sendBeat(16'h3C00, 1'b1, 1'b0);
        i_valid = 1'b1;
        i_data  = 16'h4200;
        i_last  = 1'b0;
        i_mode  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp_ready", 32'(o_ready), 32'd0);
            checkOutput("bp_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_z",     32'(o_z),     32'h4000);
            checkOutput("bp_idx",   32'(o_idx),   32'd0);
            @(posedge clk);
        end
        #1;
        i_ready = 1'b1;
        #1;
        checkOutput("bp_ready_rise", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        checkOutput("bp_accum_valid", 32'(o_valid), 32'd0);
        sendBeat(16'h3C00, 1'b1, 1'b1);
        checkOutput("bp_next_valid", 32'(o_valid), 32'd1);
        checkOutput("bp_next_z",     32'(o_z),     32'h4200);
        checkOutput("bp_next_idx",   32'(o_idx),   32'd0);
        drainResult("bp_next");

        // Reset in the middle of a frame discards it.
        sendBeat(16'h4400, 1'b0, 1'b0);
        sendBeat(16'h4500, 1'b0, 1'b0);
        sendBeat(16'h4600, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(o_valid), 32'd0);
        checkOutput("mrst_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("mrst_valid_hold", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mrst_valid_after", 32'(o_valid), 32'd0);
        sendBeat(16'h3C00, 1'b0, 1'b0);
        sendBeat(16'h4000, 1'b1, 1'b0);
        checkOutput("mrst_new_valid", 32'(o_valid), 32'd1);
        checkOutput("mrst_new_z",     32'(o_z),     32'h4000);
        checkOutput("mrst_new_idx",   32'(o_idx),   32'd1);
        checkOutput("mrst_new_ovf",   32'(o_ovf),   32'd0);
        drainResult("mrst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
